// File: rtl/uart_rx_os_if.sv
// Receive-side byte bus of the oversampling UART receiver.
// The receiver drives it through the master modport; consumers use the slave modport.
interface uart_rx_os_if;
    logic       rx_flag;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;
    logic [2:0] state;

    modport master (
        output rx_flag,
        output rx_data,
        output frame_err,
        output busy,
        output state
    );

    modport slave (
        input rx_flag,
        input rx_data,
        input frame_err,
        input busy,
        input state
    );
endinterface

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with oversampled mid-bit sampling, start-glitch rejection and
// framing-error reporting. Bytes leave as a one-clock rx_flag pulse alongside rx_data.
module uart_rx_os #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    uart_rx_os_if.master  bus
);

    localparam int DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t              state;
    logic                sync1;
    logic                sync2;
    logic                prev;
    logic [DIV_W-1:0]    div_cnt;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift;
    logic [7:0]          data_q;
    logic                flag_q;
    logic                ferr_q;
    logic                busy_q;
    logic                tick;
    logic                start_edge;

    // Sync flops reset high so a reset never fabricates a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign start_edge = prev & ~sync2;
    assign tick       = busy_q && (div_cnt == DIV_LAST);

    // Held at zero in IDLE so the first tick lands DIV cycles after the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == S_IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            flag_q   <= 1'b0;
            ferr_q   <= 1'b0;
            data_q   <= 8'h00;
            shift    <= 8'h00;
            samp_cnt <= '0;
            bit_cnt  <= 3'd0;
        end else begin
            flag_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state    <= S_START;
                        busy_q   <= 1'b1;
                        samp_cnt <= '0;
                        bit_cnt  <= 3'd0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_MID) begin
                            samp_cnt <= '0;
                            if (!sync2) begin
                                state <= S_DATA;
                            end else begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + SAMP_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt       <= '0;
                            shift[bit_cnt] <= sync2;
                            bit_cnt        <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= S_STOP;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + SAMP_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt <= '0;
                            if (sync2) begin
                                data_q <= shift;
                                flag_q <= 1'b1;
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                ferr_q <= 1'b1;
                                state  <= S_BREAK;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + SAMP_W'(1);
                        end
                    end
                end
                // No start detection here: a held-low line reports one error only.
                S_BREAK: begin
                    if (sync2) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_flag   = flag_q;
    assign bus.rx_data   = data_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven bit by bit on rx while a monitor
// checks every rx_flag / frame_err pulse against an expected queue.
module tb_uart_rx_os;

    localparam int CLK_HZ = 6_400_000;
    localparam int BAUD   = 100_000;
    localparam int OS     = 16;
    localparam int BIT    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    // {is_frame_err, expected rx_data}
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;

    always #5 clk = ~clk;

    uart_rx_os_if bus ();

    uart_rx_os #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int bclk);
        rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bclk) @(negedge clk);
        end
        rx = stop_v;
        repeat (bclk) @(negedge clk);
    endtask

    task automatic idle_bits(input int bits);
        rx = 1'b1;
        repeat (bits * BIT) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (bus.rx_flag || bus.frame_err)) begin
            check("flag_ferr_exclusive", 32'(bus.rx_flag & bus.frame_err), 32'(0));
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got flag=%0b ferr=%0b data=%0h, expected no pulse",
                         bus.rx_flag, bus.frame_err, bus.rx_data);
            end else begin
                exp_e = exp_q.pop_front();
                check("pulse_kind", 32'(bus.frame_err), 32'(exp_e[8]));
                check("pulse_data", 32'(bus.rx_data), 32'(exp_e[7:0]));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_flag",  32'(bus.rx_flag),   32'(0));
        check("reset_ferr",  32'(bus.frame_err), 32'(0));
        check("reset_busy",  32'(bus.busy),      32'(0));
        check("reset_data",  32'(bus.rx_data),   32'h00);
        check("reset_state", 32'(bus.state),     32'(0));
        rst = 1'b0;
        idle_bits(1);

        // Single byte, ideal timing
        exp_q.push_back({1'b0, 8'h41});
        send_frame(8'h41, 1'b1, BIT);
        check("t1_busy_after_flag", 32'(bus.busy), 32'(0));
        idle_bits(1);

        // Back-to-back escape sequence, one stop bit each
        exp_q.push_back({1'b0, 8'h1B});
        exp_q.push_back({1'b0, 8'h5B});
        exp_q.push_back({1'b0, 8'h41});
        send_frame(8'h1B, 1'b1, BIT);
        send_frame(8'h5B, 1'b1, BIT);
        send_frame(8'h41, 1'b1, BIT);
        idle_bits(2);

        // Start-bit glitch of 16 clocks
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check("t3_busy_on_edge", 32'(bus.busy), 32'(1));
        repeat (8) @(negedge clk);
        rx = 1'b1;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t3_busy_release", 32'(bus.busy), 32'(0));
        check("t3_data_kept", 32'(bus.rx_data), 32'h41);
        idle_bits(1);

        // Framing error followed by a held-low break, then a good byte
        exp_q.push_back({1'b1, 8'h41});
        send_frame(8'h55, 1'b0, BIT);
        repeat (3 * BIT) @(negedge clk);
        check("t4_busy_in_break", 32'(bus.busy), 32'(1));
        check("t4_data_kept", 32'(bus.rx_data), 32'h41);
        idle_bits(1);
        check("t4_busy_after_break", 32'(bus.busy), 32'(0));
        exp_q.push_back({1'b0, 8'h0D});
        send_frame(8'h0D, 1'b1, BIT);
        idle_bits(1);

        // Reset in the middle of 0xC3 after four data bits
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i < 2) ? 1'b1 : 1'b0;
            repeat (BIT) @(negedge clk);
        end
        check("t5_busy_before_rst", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("t5_rst_flag", 32'(bus.rx_flag),   32'(0));
        check("t5_rst_ferr", 32'(bus.frame_err), 32'(0));
        check("t5_rst_busy", 32'(bus.busy),      32'(0));
        check("t5_rst_data", 32'(bus.rx_data),   32'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        exp_q.push_back({1'b0, 8'h7E});
        send_frame(8'h7E, 1'b1, BIT);
        idle_bits(1);

        // Baud error of +3% and -3%
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, 66);
        idle_bits(2);
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, 62);
        idle_bits(2);
        check("t6_last_data", 32'(bus.rx_data), 32'hA5);

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
